// File: rtl/gol_matrix_scan.sv
// LED matrix scanner for the 8x8 Game-of-Life grid. It lights one row at a time and takes a
// grid snapshot once per frame. It pulses step once every FRAMES_PER_STEP frames.
module gol_matrix_scan #(
   parameter int DWELL_CYCLES    = 1000,
   parameter int BLANK_CYCLES    = 2,
   parameter int FRAMES_PER_STEP = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [63:0] grid_in,
   output logic [7:0]  row_sel,
   output logic [7:0]  col_data,
   output logic        frame_done,
   output logic        step
);

   localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam int CW = (DW > BW) ? DW : BW;
   localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_PREV = CW'((BLANK_CYCLES > 1) ? BLANK_CYCLES - 2 : 0);
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHOW, BLANK} state_t;

   state_t        state;
   logic [63:0]   snapshot;
   logic [2:0]    row_idx;
   logic [CW-1:0] cnt;
   logic [FW-1:0] frame_cnt;
   logic          frame_end;

   // Row r sits in bits 63-8r down to 56-8r. Column 0 is the MSB of that byte.
   function automatic logic [7:0] grid_row(input logic [63:0] g, input logic [2:0] r);
      grid_row = g[8*(7 - int'(r)) +: 8];
   endfunction

   function automatic logic [7:0] onehot(input logic [2:0] r);
      onehot    = 8'h00;
      onehot[r] = 1'b1;
   endfunction

   // Outputs are registered, so flag the cycle BEFORE the final blank cycle of row 7.
   always_comb begin
      frame_end = (row_idx == 3'd7) &&
                  (((state == SHOW)  && (cnt == DWELL_LAST) && (BLANK_CYCLES == 1)) ||
                   ((state == BLANK) && (cnt == BLANK_PREV) && (BLANK_CYCLES > 1)));
   end

   // NOTE: every register here is written with non-blocking assignments, so all decisions
   // in one cycle see the values from before the clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         row_sel    <= '0;
         col_data   <= '0;
         frame_done <= 1'b0;
         step       <= 1'b0;
         snapshot   <= '0;
         row_idx    <= '0;
         cnt        <= '0;
         frame_cnt  <= '0;
      end else begin
         frame_done <= frame_end;
         step       <= frame_end && (frame_cnt == FRAME_LAST);
         if (frame_end)
            frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FW'(1);

         case (state)
            IDLE: begin
               row_sel  <= '0;
               col_data <= '0;
               if (enable)
                  state <= LOAD;
            end
            LOAD: begin
               // The snapshot is loaded on this same edge, so row 0 comes straight from grid_in.
               snapshot <= grid_in;
               row_idx  <= '0;
               cnt      <= '0;
               row_sel  <= onehot(3'd0);
               col_data <= grid_row(grid_in, 3'd0);
               state    <= SHOW;
            end
            SHOW: begin
               if (cnt == DWELL_LAST) begin
                  cnt      <= '0;
                  row_sel  <= '0;
                  col_data <= '0;
                  state    <= BLANK;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            BLANK: begin
               if (cnt == BLANK_LAST) begin
                  cnt <= '0;
                  if (row_idx == 3'd7) begin
                     state <= enable ? LOAD : IDLE;
                  end else begin
                     row_idx  <= row_idx + 3'd1;
                     row_sel  <= onehot(row_idx + 3'd1);
                     col_data <= grid_row(snapshot, row_idx + 3'd1);
                     state    <= SHOW;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
